// File: rtl/wb_bus_arbiter_pkg.sv
// Purpose : shared address map, slave indices and request bundle for the Wishbone arbiter.
// Latency : n/a (constants and types only).
// Backpressure: n/a.
//
// The address-map macros double as the shared defines: any file compiled after
// this one can use `CLINT_BASE, `UART_BASE and the `SLV_* indices.
`ifndef WB_BUS_DEFINES
`define WB_BUS_DEFINES
`define CLINT_BASE 32'h0200_0000
`define UART_BASE  32'h1000_0000
`define SLV_RAM    0
`define SLV_UART   1
`define SLV_CLINT  2
`endif

package wb_bus_arbiter_pkg;

    localparam int NUM_SLV = 3;
    localparam int WAIT_W  = 8;

    // One master's request side, muxed as a unit by the grant logic.
    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wb_req_t;

endpackage

// File: rtl/wb_addr_decode.sv
// Purpose : maps a bus address onto a one-hot slave select (RAM / UART / CLINT).
// Latency : purely combinational, zero cycles.
// Backpressure: none; no state.
//
// Ports: adr (address of the granted master), slv_sel (one-hot, indexed by `SLV_*).
module wb_addr_decode
    import wb_bus_arbiter_pkg::*;
#(
    parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000,
    parameter logic [31:0] UART_MASK  = 32'hFFFF_F000
) (
    input  logic [31:0]        adr,
    output logic [NUM_SLV-1:0] slv_sel
);

    // CLINT is checked first so an overlapping UART window can never shadow it.
    always_comb begin
        slv_sel = '0;
        if ((adr & CLINT_MASK) == `CLINT_BASE) begin
            slv_sel[`SLV_CLINT] = 1'b1;
        end else if ((adr & UART_MASK) == `UART_BASE) begin
            slv_sel[`SLV_UART] = 1'b1;
        end else begin
            slv_sel[`SLV_RAM] = 1'b1;
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Purpose : 2-master / 3-slave Wishbone arbiter with round-robin grant and ack timeout.
// Latency : one cycle to grant from IDLE; ack/data pass through combinationally.
// Backpressure: slave ack stalls the master; no ack for TIMEOUT wait cycles returns err.
//
// Ports: wb_clk_i/wb_rst_n_i; m0_* (instruction fetch) and m1_* (data) Wishbone
// masters; s0_* RAM, s1_* UART, s2_* CLINT Wishbone slaves.
module wb_bus_arbiter
    import wb_bus_arbiter_pkg::*;
#(
    parameter int          TIMEOUT    = 255,
    parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000,
    parameter logic [31:0] UART_MASK  = 32'hFFFF_F000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    // master 0
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    // master 1
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    // slave 0 (RAM)
    output logic        s0_cyc_o,
    output logic        s0_stb_o,
    output logic        s0_we_o,
    output logic [31:0] s0_adr_o,
    output logic [31:0] s0_dat_o,
    output logic [3:0]  s0_sel_o,
    input  logic [31:0] s0_dat_i,
    input  logic        s0_ack_i,
    // slave 1 (UART)
    output logic        s1_cyc_o,
    output logic        s1_stb_o,
    output logic        s1_we_o,
    output logic [31:0] s1_adr_o,
    output logic [31:0] s1_dat_o,
    output logic [3:0]  s1_sel_o,
    input  logic [31:0] s1_dat_i,
    input  logic        s1_ack_i,
    // slave 2 (CLINT)
    output logic        s2_cyc_o,
    output logic        s2_stb_o,
    output logic        s2_we_o,
    output logic [31:0] s2_adr_o,
    output logic [31:0] s2_dat_o,
    output logic [3:0]  s2_sel_o,
    input  logic [31:0] s2_dat_i,
    input  logic        s2_ack_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GNT_M0 = 2'd1,
        ST_GNT_M1 = 2'd2
    } state_t;

    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

    state_t              state, state_nxt;
    logic                last_m1, last_m1_nxt;   // 1: master 1 held the most recent grant
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;

    wb_req_t             m0_req, m1_req, g_req;
    logic                gnt_m0, gnt_m1, active;
    logic [NUM_SLV-1:0]  slv_sel, slv_cyc, slv_stb, ack_vec;
    logic                slv_ack, timeout_hit;
    logic [31:0]         slv_rdat;

    assign m0_req = '{cyc: m0_cyc_i, stb: m0_stb_i, we: m0_we_i,
                      adr: m0_adr_i, dat: m0_dat_i, sel: m0_sel_i};
    assign m1_req = '{cyc: m1_cyc_i, stb: m1_stb_i, we: m1_we_i,
                      adr: m1_adr_i, dat: m1_dat_i, sel: m1_sel_i};

    // ---------------- arbitration FSM ----------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state    <= ST_IDLE;
            last_m1  <= 1'b0;      // master 0 counts as last, so master 1 wins the first tie
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            last_m1  <= last_m1_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        last_m1_nxt = last_m1;
        unique case (state)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    if (last_m1) begin
                        state_nxt   = ST_GNT_M0;
                        last_m1_nxt = 1'b0;
                    end else begin
                        state_nxt   = ST_GNT_M1;
                        last_m1_nxt = 1'b1;
                    end
                end else if (m0_cyc_i) begin
                    state_nxt   = ST_GNT_M0;
                    last_m1_nxt = 1'b0;
                end else if (m1_cyc_i) begin
                    state_nxt   = ST_GNT_M1;
                    last_m1_nxt = 1'b1;
                end
            end
            ST_GNT_M0: if (!m0_cyc_i) state_nxt = ST_IDLE;
            ST_GNT_M1: if (!m1_cyc_i) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // A grant only drives the bus while its owner still holds cyc, so a master
    // dropping cyc takes the slave cycle down in the same clock.
    assign gnt_m0 = (state == ST_GNT_M0) && m0_cyc_i;
    assign gnt_m1 = (state == ST_GNT_M1) && m1_cyc_i;
    assign active = gnt_m0 || gnt_m1;

    always_comb begin
        g_req = '0;
        if (gnt_m0) begin
            g_req = m0_req;
        end else if (gnt_m1) begin
            g_req = m1_req;
        end
    end

    // ---------------- decode and slave routing ----------------
    wb_addr_decode #(
        .CLINT_MASK (CLINT_MASK),
        .UART_MASK  (UART_MASK)
    ) u_decode (
        .adr     (g_req.adr),
        .slv_sel (slv_sel)
    );

    // Timeout depends only on the counter, never on ack, so stb has no
    // combinational path back from the slave's ack.
    assign timeout_hit = active && g_req.stb && (wait_cnt == TIMEOUT_CNT);

    assign slv_cyc = {NUM_SLV{active}} & slv_sel;
    assign slv_stb = {NUM_SLV{active && g_req.stb && !timeout_hit}} & slv_sel;

    always_comb begin
        ack_vec             = '0;
        ack_vec[`SLV_RAM]   = s0_ack_i;
        ack_vec[`SLV_UART]  = s1_ack_i;
        ack_vec[`SLV_CLINT] = s2_ack_i;
    end

    // Only the decoded slave's ack counts, and only while a grant is live.
    assign slv_ack = active && |(ack_vec & slv_sel);

    always_comb begin
        slv_rdat = '0;
        if (active) begin
            if (slv_sel[`SLV_CLINT]) begin
                slv_rdat = s2_dat_i;
            end else if (slv_sel[`SLV_UART]) begin
                slv_rdat = s1_dat_i;
            end else begin
                slv_rdat = s0_dat_i;
            end
        end
    end

    // ---------------- wait counter ----------------
    always_comb begin
        wait_cnt_nxt = wait_cnt;
        if (!active || !g_req.stb || slv_ack || timeout_hit) begin
            wait_cnt_nxt = '0;
        end else if (wait_cnt != '1) begin
            wait_cnt_nxt = wait_cnt + 1'b1;
        end
    end

    // ---------------- master responses ----------------
    assign m0_ack_o = gnt_m0 && slv_ack;
    assign m1_ack_o = gnt_m1 && slv_ack;
    assign m0_err_o = gnt_m0 && timeout_hit && !slv_ack;   // a coincident ack wins
    assign m1_err_o = gnt_m1 && timeout_hit && !slv_ack;
    assign m0_dat_o = gnt_m0 ? slv_rdat : 32'h0;
    assign m1_dat_o = gnt_m1 ? slv_rdat : 32'h0;

    // ---------------- slave outputs ----------------
    assign s0_cyc_o = slv_cyc[`SLV_RAM];
    assign s1_cyc_o = slv_cyc[`SLV_UART];
    assign s2_cyc_o = slv_cyc[`SLV_CLINT];
    assign s0_stb_o = slv_stb[`SLV_RAM];
    assign s1_stb_o = slv_stb[`SLV_UART];
    assign s2_stb_o = slv_stb[`SLV_CLINT];

    assign s0_we_o  = g_req.we;
    assign s1_we_o  = g_req.we;
    assign s2_we_o  = g_req.we;
    assign s0_adr_o = g_req.adr;
    assign s1_adr_o = g_req.adr;
    assign s2_adr_o = g_req.adr;
    assign s0_dat_o = g_req.dat;
    assign s1_dat_o = g_req.dat;
    assign s2_dat_o = g_req.dat;
    assign s0_sel_o = g_req.sel;
    assign s1_sel_o = g_req.sel;
    assign s2_sel_o = g_req.sel;

endmodule
